// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave to simple register-bus bridge with independent write/read FSMs.
// Define AXI4_LITE_REG_BRIDGE_DECERR_EN to answer out-of-range word indices with DECERR.
module axi4_lite_reg_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [ADDR_WIDTH-1:0]                     s_axi_awaddr,
    input  logic [2:0]                                s_axi_awprot,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]                     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]                   s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]                     s_axi_araddr,
    input  logic [2:0]                                s_axi_arprot,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]                     s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,
    output logic                                      reg_wr_en_o,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] reg_wr_addr_o,
    output logic [DATA_WIDTH-1:0]                     reg_wr_data_o,
    output logic [DATA_WIDTH/8-1:0]                   reg_wr_strb_o,
    output logic                                      reg_rd_en_o,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] reg_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]                     reg_rd_data_i
);
    localparam int OFS    = $clog2(DATA_WIDTH/8);
    localparam int IDX_W  = ADDR_WIDTH - OFS;
    localparam int STRB_W = DATA_WIDTH/8;
    localparam logic [IDX_W:0] REG_LIM = (IDX_W+1)'(REG_NUM);
`ifdef AXI4_LITE_REG_BRIDGE_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic              live;
    logic              aw_full, w_full;
    logic [IDX_W-1:0]  aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              wr_err, rd_err;

    logic              aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]  aw_idx_in, ar_idx_in, wr_idx_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic [STRB_W-1:0] wstrb_sel;
    logic              unused_bits;

    function automatic logic out_of_range(input logic [IDX_W-1:0] idx);
        return DECERR_EN && ({1'b0, idx} >= REG_LIM);
    endfunction

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign aw_idx_in   = s_axi_awaddr[ADDR_WIDTH-1:OFS];
    assign ar_idx_in   = s_axi_araddr[ADDR_WIDTH-1:OFS];
    assign wr_idx_sel  = aw_full ? aw_idx : aw_idx_in;
    assign wdata_sel   = w_full ? w_data : s_axi_wdata;
    assign wstrb_sel   = w_full ? w_strb : s_axi_wstrb;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[OFS-1:0], s_axi_araddr[OFS-1:0]};

    // live keeps the ready outputs low until the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            live    <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            live    <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_full || aw_hs) && (w_full || w_hs)) w_next = W_EXEC;
            W_EXEC:  w_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_EXEC;
            R_EXEC:  r_next = R_WAIT;
            R_WAIT:  r_next = R_RESP;
            R_RESP:  if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = live && (w_state == W_IDLE) && !aw_full;
        s_axi_wready  = live && (w_state == W_IDLE) && !w_full;
        s_axi_bvalid  = (w_state == W_RESP);
        s_axi_bresp   = wr_err ? 2'b11 : 2'b00;
        reg_wr_en_o   = (w_state == W_EXEC) && !wr_err;
        s_axi_arready = live && (r_state == R_IDLE);
        s_axi_rvalid  = (r_state == R_RESP);
        s_axi_rresp   = rd_err ? 2'b11 : 2'b00;
        reg_rd_en_o   = (r_state == R_EXEC) && !rd_err;
    end

    // Slots, register-bus outputs and read data; bus outputs only move on a new transaction
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            wr_err        <= 1'b0;
            rd_err        <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
            reg_wr_strb_o <= '0;
            reg_rd_addr_o <= '0;
            s_axi_rdata   <= '0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= aw_idx_in;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (w_state == W_IDLE && w_next == W_EXEC) begin
                reg_wr_addr_o <= wr_idx_sel;
                reg_wr_data_o <= wdata_sel;
                reg_wr_strb_o <= wstrb_sel;
                wr_err        <= out_of_range(wr_idx_sel);
            end
            if (w_state == W_RESP && s_axi_bready) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (ar_hs) begin
                reg_rd_addr_o <= ar_idx_in;
                rd_err        <= out_of_range(ar_idx_in);
            end
            if (r_state == R_WAIT) begin
                s_axi_rdata <= rd_err ? '0 : reg_rd_data_i;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Directed bench for axi4_lite_reg_bridge: vector table plus multi-cycle corner sequences.
module tb_axi4_lite_reg_bridge;
`ifdef AXI4_LITE_REG_BRIDGE_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, rd_data = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0, wr_strb;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic [1:0]  bresp, rresp;
    logic        wr_en, rd_en;
    logic [29:0] wr_addr, rd_addr;
    logic [31:0] wr_data;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    axi4_lite_reg_bridge dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_wr_en_o(wr_en), .reg_wr_addr_o(wr_addr), .reg_wr_data_o(wr_data), .reg_wr_strb_o(wr_strb),
        .reg_rd_en_o(rd_en), .reg_rd_addr_o(rd_addr), .reg_rd_data_i(rd_data)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [29:0] idx;
        bit          en;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input vec_t v);
        step();
        awaddr = v.addr; awvalid = 1; wdata = v.data; wstrb = v.strb; wvalid = 1; bready = 1;
        @(negedge clk);
        check("wr_aw_ready", {awready, wready}, 2'b11);
        step();
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("wr_strobe", wr_en, v.en);
        if (v.en) begin
            check("wr_idx", wr_addr, v.idx);
            check("wr_data", wr_data, v.data);
            check("wr_strb", wr_strb, v.strb);
        end
        check("wr_bvalid_early", bvalid, 0);
        step();
        @(negedge clk);
        check("wr_bvalid", bvalid, 1);
        check("wr_bresp", bresp, v.resp);
        check("wr_strobe_once", wr_en, 0);
        step();
        @(negedge clk);
        check("wr_bvalid_drop", bvalid, 0);
        check("wr_idle_ready", {awready, wready}, 2'b11);
        if (v.en) check("wr_idx_hold", wr_addr, v.idx);
    endtask

    task automatic do_read(input vec_t v);
        step();
        araddr = v.addr; arvalid = 1; rready = 1;
        @(negedge clk);
        check("rd_ar_ready", arready, 1);
        step();
        arvalid = 0;
        @(negedge clk);
        check("rd_strobe", rd_en, v.en);
        if (v.en) check("rd_idx", rd_addr, v.idx);
        step();
        rd_data = v.data;
        @(negedge clk);
        check("rd_rvalid_early", rvalid, 0);
        step();
        rd_data = 32'hBAD0_0BAD;
        @(negedge clk);
        check("rd_rvalid", rvalid, 1);
        check("rd_rresp", rresp, v.resp);
        check("rd_rdata", rdata, v.exp_rdata);
        check("rd_ar_busy", arready, 0);
        step();
        @(negedge clk);
        check("rd_rvalid_drop", rvalid, 0);
        check("rd_idle_ready", arready, 1);
    endtask

    initial begin
        int cnt_b, cnt_r, cnt_s;
        vecs[0] = '{1, 32'h08, 32'hDEADBEEF, 4'hF, 30'd2, 1, 2'b00, 32'h0};
        vecs[1] = '{1, 32'h0E, 32'h000000FF, 4'h1, 30'd3, 1, 2'b00, 32'h0};
        vecs[2] = '{1, 32'h3C, 32'h11223344, 4'hA, 30'd15, 1, 2'b00, 32'h0};
        vecs[3] = '{1, 32'h40, 32'h00000055, 4'hF, 30'd16, !DECERR, DECERR ? 2'b11 : 2'b00, 32'h0};
        vecs[4] = '{0, 32'h0C, 32'hCAFEF00D, 4'h0, 30'd3, 1, 2'b00, 32'hCAFEF00D};
        vecs[5] = '{0, 32'h3F, 32'h0BADF00D, 4'h0, 30'd15, 1, 2'b00, 32'h0BADF00D};
        vecs[6] = '{0, 32'h40, 32'h13579BDF, 4'h0, 30'd16, !DECERR, DECERR ? 2'b11 : 2'b00,
                    DECERR ? 32'h0 : 32'h13579BDF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {awready, wready, arready}, 3'b000);
        check("rst_valid", {bvalid, rvalid, wr_en, rd_en}, 4'b0000);
        check("rst_resp", {bresp, rresp}, 4'b0000);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus", {wr_addr, rd_addr, wr_data, wr_strb}, 96'h0);
        #1 rst_n = 1;
        @(negedge clk);
        check("rel_ready", {awready, wready, arready}, 3'b111);

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i]);
            else            do_read(vecs[i]);
        end

        // W leads AW by three cycles
        step();
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1; bready = 1;
        @(negedge clk);
        check("wfirst_wready", wready, 1);
        step();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wfirst_slot_full", {wready, awready, wr_en, bvalid}, 4'b0100);
            step();
        end
        awaddr = 32'h04; awvalid = 1;
        @(negedge clk);
        check("wfirst_awready", awready, 1);
        step();
        awvalid = 0;
        @(negedge clk);
        check("wfirst_strobe", {wr_en, wr_addr}, {1'b1, 30'd1});
        check("wfirst_data", wr_data, 32'h12345678);
        cnt_b = 0; cnt_s = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            cnt_b += int'(bvalid);
            cnt_s += int'(wr_en);
        end
        check("wfirst_one_bresp", cnt_b, 1);
        check("wfirst_one_strobe", cnt_s, 0);

        // Read held off by rready for five cycles
        step();
        araddr = 32'h0C; arvalid = 1; rready = 0;
        @(negedge clk);
        check("hold_arready", arready, 1);
        step();
        arvalid = 0;
        @(negedge clk);
        check("hold_strobe", {rd_en, rd_addr}, {1'b1, 30'd3});
        step();
        rd_data = 32'hA5A5A5A5;
        @(negedge clk);
        step();
        rd_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rvalid", {rvalid, arready}, 2'b10);
            check("hold_rdata", rdata, 32'hA5A5A5A5);
            step();
        end
        rready = 1;
        @(negedge clk);
        check("hold_last", rvalid, 1);
        step();
        @(negedge clk);
        check("hold_done", {rvalid, arready}, 2'b01);

        // Concurrent write index 3 and read index 5
        step();
        awaddr = 32'h0C; awvalid = 1; wdata = 32'h0F0F0F0F; wstrb = 4'h3; wvalid = 1;
        araddr = 32'h14; arvalid = 1; bready = 1; rready = 1;
        @(negedge clk);
        check("conc_ready", {awready, wready, arready}, 3'b111);
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        check("conc_strobes", {wr_en, rd_en}, 2'b11);
        check("conc_idx", {wr_addr, rd_addr}, {30'd3, 30'd5});
        step();
        rd_data = 32'h00000077;
        @(negedge clk);
        check("conc_b_first", {bvalid, rvalid}, 2'b10);
        step();
        @(negedge clk);
        check("conc_r_next", {bvalid, rvalid}, 2'b01);
        check("conc_rdata", rdata, 32'h77);
        step();

        // Reset during W_RESP / R_WAIT
        awaddr = 32'h20; awvalid = 1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1;
        araddr = 32'h24; arvalid = 1; bready = 0; rready = 0;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        step();
        @(negedge clk);
        check("arst_pre_bvalid", bvalid, 1);
        #1 rst_n = 0;
        #1;
        check("arst_drop", {bvalid, rvalid, awready, wready, arready}, 5'b0);
        check("arst_strobes", {wr_en, rd_en}, 2'b00);
        bready = 1; rready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("arst_rel_ready", {awready, wready, arready}, 3'b111);
        cnt_b = 0; cnt_r = 0; cnt_s = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            cnt_b += int'(bvalid);
            cnt_r += int'(rvalid);
            cnt_s += int'(wr_en) + int'(rd_en);
        end
        check("arst_no_resp", {cnt_b[7:0], cnt_r[7:0], cnt_s[7:0]}, 24'h0);
        do_write('{1, 32'h18, 32'hFEEDC0DE, 4'hF, 30'd6, 1, 2'b00, 32'h0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
